mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles dmem_req is held without dmem_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  execute-stage result valid this cycle.
REQ-005 in_ready  output  1  stage can accept a new result.
REQ-006 alu_op  input  6  opcode; LW=6'b001000, SW=6'b001010, all others are non-memory.
REQ-007 alu_result  input  32  execute result; LW/SW effective address.
REQ-008 store_data  input  32  rs2 value for SW.
REQ-009 rd_addr  input  5  destination register.
REQ-010 flush  input  1  squash accepted and in-flight work.
REQ-011 dmem_req, dmem_we  output  1 each  memory request; write enable.
REQ-012 dmem_addr, dmem_wdata  output  32 each  word address; store data.
REQ-013 dmem_ack  input  1  request completed this cycle; dmem_rdata valid when acked read.
REQ-014 dmem_rdata  input  32  load data.
REQ-015 wb_valid, wb_we  output  1 each  writeback pulse; register-file write enable.
REQ-016 wb_rd, wb_data  output  5, 32  writeback register and value.
REQ-017 mem_err  output  2  one-cycle error code with wb_valid: 00 none, 01 misaligned, 10 timeout.

Function
REQ-018 States SHALL be IDLE and ACCESS; in_ready = 1 only in IDLE with rst_n high.
REQ-019 Accept = in_valid & in_ready & ~flush; flush with in_valid in IDLE drops the input, no output.
REQ-020 Non-memory accept: next cycle wb_valid=1, wb_we=(rd_addr!=0), wb_rd=rd_addr, wb_data=alu_result, mem_err=00; state stays IDLE (1-cycle latency, back-to-back every cycle).
REQ-021 LW/SW accept with alu_result[1:0]!=0: no memory request; next cycle wb_valid=1, wb_we=0, mem_err=01.
REQ-022 LW/SW accept, aligned: next cycle state ACCESS, dmem_req=1, dmem_addr=alu_result, dmem_we=1 for SW else 0, dmem_wdata=store_data (SW) else 0.
REQ-023 dmem_req, dmem_addr, dmem_we, dmem_wdata SHALL be registered and held stable throughout ACCESS.
REQ-024 dmem_ack sampled only while dmem_req=1; ack in IDLE ignored.
REQ-025 ACCESS + dmem_ack: next cycle dmem_req=0, state IDLE, wb_valid=1, mem_err=00; LW: wb_data=dmem_rdata, wb_we=(rd_addr!=0); SW: wb_we=0, wb_data=0.
REQ-026 Wait counter (8 bits) SHALL clear on entry to ACCESS, increment each ACCESS cycle without ack; at count TIMEOUT-1 without ack: next cycle dmem_req=0, state IDLE, wb_valid=1, wb_we=0, mem_err=10.
REQ-027 Ack on the timeout cycle SHALL win: completes as REQ-025.
REQ-028 flush in ACCESS SHALL set squash flag; request is not abandoned; completion (ack or timeout) returns to IDLE with wb_valid=0; flag cleared on exit.
REQ-029 wb_valid and mem_err SHALL be single-cycle pulses; wb_we=0 whenever wb_valid=0.
REQ-030 Earliest new accept after ACCESS is the cycle state returns to IDLE.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, counter 0, squash 0, and all outputs 0 except in_ready=0 while rst_n low.
REQ-032 Reset mid-ACCESS SHALL drop dmem_req asynchronously; later dmem_ack is ignored.
REQ-033 First accept possible on first rising edge with rst_n high.

Verification
REQ-034 ADD result 0x0000_0005, rd=3, in_valid one cycle -> next cycle wb_valid=1, wb_we=1, wb_rd=3, wb_data=5, mem_err=00.
REQ-035 LW addr 0x100, rd=7, ack after 3 ACCESS cycles with rdata 0xDEADBEEF -> dmem_req high 3 cycles, addr 0x100, we=0; then wb_data=0xDEADBEEF, wb_we=1, wb_rd=7; in_ready=0 throughout ACCESS.
REQ-036 SW addr 0x204, store_data 0x12345678, ack next cycle -> dmem_we=1, dmem_wdata=0x12345678; wb_valid=1, wb_we=0.
REQ-037 LW addr 0x102 -> no dmem_req; wb_valid=1, wb_we=0, mem_err=01.
REQ-038 LW addr 0x40, never acked, TIMEOUT=64 -> dmem_req high exactly 64 cycles, then mem_err=10, wb_we=0; ack at cycle 64 instead -> normal load writeback.
REQ-039 LW in ACCESS, flush pulse then ack -> wb_valid stays 0; separately rst_n low mid-ACCESS -> dmem_req 0 without clock edge, outputs 0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bundle of execute-side, data-memory and writeback signals around the memory stage.
// slave is the stage itself; master is everything around it (execute, memory, writeback).
interface mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alu_op;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  mem_err;

  modport master (
    output in_valid, alu_op, alu_result, store_data, rd_addr, flush, dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, mem_err
  );

  modport slave (
    input  in_valid, alu_op, alu_result, store_data, rd_addr, flush, dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, mem_err
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through in one cycle, performs aligned LW/SW
// with a bounded-wait data-memory handshake, and reports misalignment or timeout on writeback.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001010;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic        squash_reg;
  logic        is_load_reg;
  logic [4:0]  rd_reg;
  logic        dmem_req_reg;
  logic        dmem_we_reg;
  logic [31:0] dmem_addr_reg;
  logic [31:0] dmem_wdata_reg;
  logic        wb_valid_reg;
  logic        wb_we_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_data_reg;
  logic [1:0]  mem_err_reg;

  logic accept;
  logic is_mem;
  logic is_store;
  logic misaligned;
  logic acked;
  logic done;
  logic squashed;

  assign bus.in_ready   = (state_reg == IDLE) & rst_n;
  assign accept         = bus.in_valid & bus.in_ready & ~bus.flush;
  assign is_store       = (bus.alu_op == OP_SW);
  assign is_mem         = (bus.alu_op == OP_LW) | is_store;
  assign misaligned     = (bus.alu_result[1:0] != 2'b00);
  // ack is only meaningful while a request is outstanding
  assign acked          = dmem_req_reg & bus.dmem_ack;
  assign done           = acked | (cnt_reg == CNT_LAST);
  // a flush arriving on the completion cycle squashes that completion too
  assign squashed       = squash_reg | bus.flush;

  assign bus.dmem_req   = dmem_req_reg;
  assign bus.dmem_we    = dmem_we_reg;
  assign bus.dmem_addr  = dmem_addr_reg;
  assign bus.dmem_wdata = dmem_wdata_reg;
  assign bus.wb_valid   = wb_valid_reg;
  assign bus.wb_we      = wb_we_reg;
  assign bus.wb_rd      = wb_rd_reg;
  assign bus.wb_data    = wb_data_reg;
  assign bus.mem_err    = mem_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 8'd0;
      squash_reg     <= 1'b0;
      is_load_reg    <= 1'b0;
      rd_reg         <= 5'd0;
      dmem_req_reg   <= 1'b0;
      dmem_we_reg    <= 1'b0;
      dmem_addr_reg  <= 32'd0;
      dmem_wdata_reg <= 32'd0;
      wb_valid_reg   <= 1'b0;
      wb_we_reg      <= 1'b0;
      wb_rd_reg      <= 5'd0;
      wb_data_reg    <= 32'd0;
      mem_err_reg    <= 2'b00;
    end else begin
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_rd_reg    <= 5'd0;
      wb_data_reg  <= 32'd0;
      mem_err_reg  <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid_reg <= 1'b1;
              wb_we_reg    <= (bus.rd_addr != 5'd0);
              wb_rd_reg    <= bus.rd_addr;
              wb_data_reg  <= bus.alu_result;
            end else if (misaligned) begin
              wb_valid_reg <= 1'b1;
              wb_rd_reg    <= bus.rd_addr;
              mem_err_reg  <= 2'b01;
            end else begin
              state_reg      <= ACCESS;
              cnt_reg        <= 8'd0;
              squash_reg     <= 1'b0;
              is_load_reg    <= ~is_store;
              rd_reg         <= bus.rd_addr;
              dmem_req_reg   <= 1'b1;
              dmem_we_reg    <= is_store;
              dmem_addr_reg  <= bus.alu_result;
              dmem_wdata_reg <= is_store ? bus.store_data : 32'd0;
            end
          end
        end
        ACCESS: begin
          if (done) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            squash_reg     <= 1'b0;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= 32'd0;
            dmem_wdata_reg <= 32'd0;
            if (!squashed) begin
              wb_valid_reg <= 1'b1;
              wb_rd_reg    <= rd_reg;
              if (acked) begin
                if (is_load_reg) begin
                  wb_we_reg   <= (rd_reg != 5'd0);
                  wb_data_reg <= bus.dmem_rdata;
                end
              end else begin
                mem_err_reg <= 2'b10;
              end
            end
          end else begin
            cnt_reg    <= cnt_reg + 8'd1;
            squash_reg <= squashed;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: the driver pushes expected writebacks, a monitor
// pops and compares them on every wb_valid pulse; a memory responder model lives in the driver.
module tb_mem_stage;
  localparam int TIMEOUT = 64;
  localparam logic [5:0] OP_LW = 6'b001000;
  localparam logic [5:0] OP_SW = 6'b001010;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  err;
    bit          chk_data;
    bit          chk_rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();
  mem_stage #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wb_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_wb: got wb_valid=1 rd=%0d data=%h expected no writeback at %0t",
                   bus.wb_rd, bus.wb_data, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          $display("[TB] wb rd=%0d we=%0b data=%h err=%0d", bus.wb_rd, bus.wb_we, bus.wb_data, bus.mem_err);
          check("wb_we", 32'(bus.wb_we), 32'(e.we));
          check("mem_err", 32'(bus.mem_err), 32'(e.err));
          if (e.chk_rd) check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
          if (e.chk_data) check("wb_data", bus.wb_data, e.data);
        end
      end else begin
        check("idle_wb_we_err", 32'({bus.wb_we, bus.mem_err}), 32'd0);
      end
    end
  end

  task automatic clear_inputs();
    bus.in_valid   = 1'b0;
    bus.alu_op     = 6'd0;
    bus.alu_result = 32'd0;
    bus.store_data = 32'd0;
    bus.rd_addr    = 5'd0;
    bus.flush      = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
  endtask

  // lat: ACCESS cycle (1..TIMEOUT) on which ack arrives, 0 = never; fl_cyc: ACCESS cycle of flush, 0 = none
  task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input bit fl_in, input int lat, input int fl_cyc);
    bit is_mem, is_ld, aligned;
    int last;
    exp_t e;
    is_ld   = (op == OP_LW);
    is_mem  = is_ld || (op == OP_SW);
    aligned = (res[1:0] == 2'b00);
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.alu_result = res;
    bus.store_data = sd; bus.rd_addr = rd; bus.flush = fl_in;
    if (!fl_in) begin
      e = '{data: 32'd0, rd: rd, we: 1'b0, err: 2'd0, chk_data: 1'b0, chk_rd: 1'b0};
      if (!is_mem) begin
        e.data = res; e.we = (rd != 0); e.chk_data = 1; e.chk_rd = 1;
        q.push_back(e);
      end else if (!aligned) begin
        e.err = 2'd1;
        q.push_back(e);
      end else if (fl_cyc == 0) begin
        if (lat == 0) e.err = 2'd2;
        else if (is_ld) begin
          e.data = rd_mem(res); e.we = (rd != 0); e.chk_data = 1; e.chk_rd = 1;
        end else e.chk_data = 1;
        q.push_back(e);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    if (fl_in || !is_mem || !aligned) begin
      check("no_dmem_req", 32'(bus.dmem_req), 32'd0);
    end else begin
      last = (lat == 0) ? TIMEOUT : lat;
      for (int c = 1; c <= last; c++) begin
        check("dmem_req_held", 32'(bus.dmem_req), 32'd1);
        check("dmem_addr", bus.dmem_addr, res);
        check("dmem_we", 32'(bus.dmem_we), 32'(!is_ld));
        check("dmem_wdata", bus.dmem_wdata, is_ld ? 32'd0 : sd);
        check("in_ready_access", 32'(bus.in_ready), 32'd0);
        bus.dmem_ack   = (c == lat);
        bus.dmem_rdata = (c == lat && is_ld) ? rd_mem(res) : $urandom;
        bus.flush      = (c == fl_cyc);
        @(negedge clk);
        bus.dmem_ack = 1'b0; bus.flush = 1'b0;
      end
      check("dmem_req_released", 32'(bus.dmem_req), 32'd0);
      check("in_ready_after", 32'(bus.in_ready), 32'd1);
      if (lat > 0 && !is_ld) mem[res] = sd;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_outputs", 32'({bus.dmem_req, bus.dmem_we, bus.wb_valid, bus.wb_we, bus.mem_err}), 32'd0);
    check("rst_buses", bus.dmem_addr | bus.dmem_wdata | bus.wb_data, 32'd0);
    rst_n = 1'b1;

    // directed scenarios
    issue(6'b000000, 32'h5, 32'h0, 5'd3, 0, 0, 0);
    issue(OP_LW, 32'h100, 32'h0, 5'd7, 0, 3, 0);
    issue(OP_SW, 32'h204, 32'h1234_5678, 5'd0, 0, 1, 0);
    issue(OP_LW, 32'h204, 32'h0, 5'd9, 0, 2, 0);
    issue(OP_LW, 32'h102, 32'h0, 5'd4, 0, 0, 0);
    issue(OP_LW, 32'h40, 32'h0, 5'd5, 0, 0, 0);
    issue(OP_LW, 32'h40, 32'h0, 5'd5, 0, TIMEOUT, 0);
    issue(OP_LW, 32'h44, 32'h0, 5'd6, 0, 4, 2);
    issue(OP_LW, 32'h48, 32'h0, 5'd6, 1, 0, 0);
    issue(6'b000001, 32'hCAFE, 32'h0, 5'd0, 0, 0, 0);

    // back-to-back non-memory results
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      @(negedge clk);
      check("in_ready_b2b", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1; bus.alu_op = 6'(i + 16); bus.alu_result = $urandom;
      bus.rd_addr = 5'(i + 1); bus.flush = 1'b0;
      e = '{data: bus.alu_result, rd: 5'(i + 1), we: 1'b1, err: 2'd0, chk_data: 1'b1, chk_rd: 1'b1};
      q.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      logic [31:0] res;
      int sel, lat, fl_cyc;
      bit fl_in;
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        op = 6'($urandom);
        if (op == OP_LW || op == OP_SW) op = 6'd0;
      end else op = (sel < 7) ? OP_LW : OP_SW;
      res = 32'h200 + {26'd0, 4'($urandom), 2'b00};
      if ($urandom_range(0, 9) == 0) res[1:0] = 2'($urandom_range(1, 3));
      sel = $urandom_range(0, 19);
      lat = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : (sel < 4) ? $urandom_range(7, 20) : $urandom_range(1, 6);
      fl_cyc = 0;
      if ($urandom_range(0, 9) == 0) fl_cyc = $urandom_range(1, (lat == 0) ? TIMEOUT : lat);
      fl_in = ($urandom_range(0, 19) == 0);
      issue(op, res, $urandom, 5'($urandom), fl_in, lat, fl_cyc);
    end

    // reset in the middle of an access
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = OP_LW; bus.alu_result = 32'h300; bus.rd_addr = 5'd8;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_rst_req_before", 32'(bus.dmem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_async", 32'(bus.dmem_req), 32'd0);
    check("mid_rst_outputs", 32'({bus.in_ready, bus.dmem_we, bus.wb_valid, bus.wb_we, bus.mem_err}), 32'd0);
    check("mid_rst_addr", bus.dmem_addr, 32'd0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_req", 32'(bus.dmem_req), 32'd0);
    bus.dmem_ack = 1'b0;
    issue(6'b000011, 32'h77, 32'h0, 5'd2, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
